// File: rtl/spi_master.sv
// spi_master
//   Single-transfer SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//   Generates SCLK/MOSI/CS from the system clock and captures MISO.
//
// Parameters
//   WIDTH   : bits per transfer (>= 2)
//   CLK_DIV : CLK cycles per SCLK half-period (>= 1)
//
// Ports
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-high reset
//   START    in   transfer request, sampled only while BUSY=0
//   TX_DATA  in   word to send, captured when START is accepted
//   BUSY     out  high while a transfer is in progress
//   DONE     out  one-cycle pulse when RX_DATA is updated
//   RX_DATA  out  last received word, held until the next DONE
//   SCLK     out  SPI clock, idles low
//   MOSI     out  SPI data out
//   MISO     in   SPI data in (sampled raw, slave is clocked by our SCLK)
//   CS       out  chip select, active low, idles high
module spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] TX_DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             CS
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIGH, SLOW, TRAIL} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt, div_cnt_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0]   shift_tx, shift_tx_n;
  logic [WIDTH-1:0]   shift_rx, shift_rx_n;
  logic [WIDTH-1:0]   rx_data_n;
  logic               busy_n, done_n, sclk_n, mosi_n, cs_n;
  logic               div_last;
  logic [WIDTH-1:0]   rx_shifted;

  assign div_last   = (div_cnt == DIV_LAST);
  assign rx_shifted = {shift_rx[WIDTH-2:0], MISO};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shift_tx <= '0;
      shift_rx <= '0;
      RX_DATA  <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      CS       <= 1'b1;
    end else begin
      state    <= state_n;
      div_cnt  <= div_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift_tx <= shift_tx_n;
      shift_rx <= shift_rx_n;
      RX_DATA  <= rx_data_n;
      BUSY     <= busy_n;
      DONE     <= done_n;
      SCLK     <= sclk_n;
      MOSI     <= mosi_n;
      CS       <= cs_n;
    end
  end

  // Next-state logic also computes the next value of every output, so all
  // pins come straight from flops.
  always_comb begin
    state_n    = state;
    div_cnt_n  = div_cnt;
    bit_cnt_n  = bit_cnt;
    shift_tx_n = shift_tx;
    shift_rx_n = shift_rx;
    rx_data_n  = RX_DATA;
    busy_n     = BUSY;
    done_n     = 1'b0;
    sclk_n     = SCLK;
    mosi_n     = MOSI;
    cs_n       = CS;

    unique case (state)
      IDLE: begin
        if (START) begin
          state_n    = LEAD;
          shift_tx_n = TX_DATA;
          div_cnt_n  = '0;
          bit_cnt_n  = '0;
          busy_n     = 1'b1;
          cs_n       = 1'b0;
          sclk_n     = 1'b0;
          mosi_n     = TX_DATA[WIDTH-1];
        end
      end

      LEAD: begin
        if (div_last) begin
          state_n    = SHIGH;
          div_cnt_n  = '0;
          sclk_n     = 1'b1;
          shift_rx_n = rx_shifted;
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end

      SHIGH: begin
        if (div_last) begin
          div_cnt_n = '0;
          sclk_n    = 1'b0;
          // The low half after the last bit becomes TRAIL, so the bit
          // count decides between SLOW and TRAIL here.
          if (bit_cnt == BIT_LAST) begin
            state_n = TRAIL;
            mosi_n  = 1'b0;
          end else begin
            state_n    = SLOW;
            shift_tx_n = shift_tx << 1;
            mosi_n     = shift_tx[WIDTH-2];
          end
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end

      SLOW: begin
        if (div_last) begin
          state_n    = SHIGH;
          div_cnt_n  = '0;
          bit_cnt_n  = bit_cnt + BIT_W'(1);
          sclk_n     = 1'b1;
          shift_rx_n = rx_shifted;
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end

      TRAIL: begin
        if (div_last) begin
          state_n   = IDLE;
          div_cnt_n = '0;
          cs_n      = 1'b1;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          rx_data_n = shift_rx;
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master
//   Randomized and directed bench for spi_master. Instance a uses the
//   default geometry (WIDTH=8, CLK_DIV=2) with either a loopback or an echo
//   slave on MISO; instance b uses WIDTH=16, CLK_DIV=1 in loopback.
module tb_spi_master;

  localparam int W_A   = 8;
  localparam int DIV_A = 2;
  localparam int CS_A  = DIV_A * (2 * W_A + 1);

  logic clk, rst;

  logic           start_a, busy_a, done_a, sclk_a, mosi_a, miso_a, cs_a;
  logic [W_A-1:0] tx_a, rx_a;
  logic           start_b, busy_b, done_b, sclk_b, mosi_b, cs_b;
  logic [15:0]    tx_b, rx_b;

  spi_master #(.WIDTH(W_A), .CLK_DIV(DIV_A)) u_dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .TX_DATA(tx_a), .BUSY(busy_a),
    .DONE(done_a), .RX_DATA(rx_a), .SCLK(sclk_a), .MOSI(mosi_a),
    .MISO(miso_a), .CS(cs_a)
  );

  spi_master #(.WIDTH(16), .CLK_DIV(1)) u_dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .TX_DATA(tx_b), .BUSY(busy_b),
    .DONE(done_b), .RX_DATA(rx_b), .SCLK(sclk_b), .MOSI(mosi_b),
    .MISO(mosi_b), .CS(cs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Echo slave: returns on MISO the bit it captured at the previous SCLK
  // rising edge, and 0 before the first one.
  bit   echo_mode;
  logic echo_q;
  always @(posedge sclk_a or posedge cs_a) begin
    if (cs_a) echo_q <= 1'b0;
    else      echo_q <= mosi_a;
  end
  assign miso_a = echo_mode ? echo_q : mosi_a;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: the master is idle unless a transfer was accepted
  // within the last CS_A edges; an accepted transfer owes one DONE.
  typedef struct packed {
    logic [W_A-1:0] tx;
    bit             echo;
  } xfer_t;

  xfer_t exp_q[$];
  int    m_left = 0;
  bit    abort_seen = 0;

  always @(posedge clk) begin
    if (rst) begin
      if (m_left != 0) abort_seen = 1;
      m_left = 0;
      exp_q.delete();
    end else if (m_left == 0) begin
      if (start_a === 1'b1) begin
        exp_q.push_back('{tx: tx_a, echo: echo_mode});
        m_left = CS_A;
      end
    end else begin
      m_left--;
    end
  end

  function automatic logic [W_A-1:0] exp_rx(input xfer_t x);
    return x.echo ? (x.tx >> 1) : x.tx;
  endfunction

  // Pin monitor for instance a, sampled on the falling edge.
  logic           cs_p = 1'b1, sclk_p = 1'b0, mosi_p = 1'b0;
  int             cs_cnt = 0, edges = 0, n_xfer = 0;
  logic [W_A-1:0] bits = '0;
  bit             unstable = 0;

  always @(negedge clk) begin
    if (cs_p === 1'b1 && cs_a === 1'b0) begin
      cs_cnt = 0; edges = 0; bits = '0; unstable = 0;
    end
    if (cs_a === 1'b0) begin
      cs_cnt++;
      if (sclk_a === 1'b1 && sclk_p === 1'b0) begin
        edges++;
        bits = {bits[W_A-2:0], mosi_a};
        if (mosi_a !== mosi_p) unstable = 1;
      end
    end
    if (cs_p === 1'b0 && cs_a === 1'b1) begin
      if (abort_seen) begin
        chk("abort_no_done", done_a, 0);
        abort_seen = 0;
      end else if (exp_q.size() == 0) begin
        chk("unexpected_xfer", exp_q.size(), 1);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        n_xfer++;
        chk("cs_low_len", cs_cnt, CS_A);
        chk("sclk_edges", edges, W_A);
        chk("mosi_word", bits, e.tx);
        chk("mosi_stable", unstable, 0);
        chk("done_pulse", done_a, 1);
        chk("rx_data", rx_a, exp_rx(e));
      end
    end else if (done_a === 1'b1) begin
      chk("spurious_done", done_a, 0);
    end
    cs_p = cs_a; sclk_p = sclk_a; mosi_p = mosi_a;
  end

  task automatic wait_done(input int limit);
    int k = 0;
    do begin @(negedge clk); k++; end while (done_a !== 1'b1 && k < limit);
    if (done_a !== 1'b1) chk("done_timeout", done_a, 1);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((m_left != 0 || exp_q.size() != 0) && k < limit) begin
      @(negedge clk); k++;
    end
    chk("idle_pending", exp_q.size(), 0);
  endtask

  task automatic send_a(input logic [W_A-1:0] d, input bit echo);
    echo_mode = echo;
    tx_a      = d;
    start_a   = 1'b1;
    @(negedge clk);
    start_a   = 1'b0;
  endtask

  initial begin
    int base, gap, k, bcs, bedges, last_rise, bad_period;
    logic [15:0] bbits;
    logic bsclk_p;

    rst = 1'b1; start_a = 1'b0; tx_a = '0; echo_mode = 0;
    start_b = 1'b0; tx_b = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_cs", cs_a, 1);
    chk("rst_sclk", sclk_a, 0);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_rx", rx_a, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback 0xA5
    send_a(8'hA5, 0);
    wait_done(100);
    repeat (3) @(negedge clk);

    // Echo slave, back-to-back 0xFF then 0x00 with START in the DONE cycle
    send_a(8'hFF, 1);
    wait_done(100);
    chk("b2b_cs_high_in_done", cs_a, 1);
    tx_a = 8'h00; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("b2b_cs_low_again", cs_a, 0);
    wait_done(100);
    repeat (3) @(negedge clk);

    // START held for 40 cycles, TX_DATA changes mid-transfer
    base = n_xfer;
    echo_mode = 0; tx_a = 8'h3C; start_a = 1'b1;
    repeat (5) @(negedge clk);
    tx_a = 8'h99;
    repeat (35) @(negedge clk);
    start_a = 1'b0;
    wait_idle(200);
    chk("held_start_xfers", n_xfer - base, 2);
    chk("held_start_rx", rx_a, 8'h99);
    repeat (2) @(negedge clk);

    // Reset 10 cycles into a transfer
    base = n_xfer;
    send_a(8'h77, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cs", cs_a, 1);
    chk("abort_sclk", sclk_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_mosi", mosi_a, 0);
    chk("abort_rx", rx_a, 0);
    repeat (5) @(negedge clk);
    chk("abort_no_xfer", n_xfer - base, 0);
    send_a(8'h5A, 0);
    wait_done(100);
    chk("after_abort_rx", rx_a, 8'h5A);
    repeat (2) @(negedge clk);

    // Randomized transfers, random slave, random gaps (0 = START in DONE cycle)
    for (int i = 0; i < 20; i++) begin
      send_a(8'($urandom), 1'($urandom_range(0, 1)));
      wait_done(100);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end
    wait_idle(200);
    chk("all_done_seen", exp_q.size(), 0);

    // Instance b: WIDTH=16, CLK_DIV=1, loopback 0x1234
    tx_b = 16'h1234; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    bcs = 0; bedges = 0; bbits = '0; last_rise = -1; bad_period = 0;
    bsclk_p = 1'b0; k = 0;
    while (done_b !== 1'b1 && k < 200) begin
      if (cs_b === 1'b0) bcs++;
      if (sclk_b === 1'b1 && bsclk_p === 1'b0) begin
        bedges++;
        bbits = {bbits[14:0], mosi_b};
        if (last_rise >= 0 && k - last_rise != 2) bad_period++;
        last_rise = k;
      end
      bsclk_p = sclk_b;
      @(negedge clk); k++;
    end
    chk("b_done", done_b, 1);
    chk("b_cs_low_len", bcs, 33);
    chk("b_sclk_edges", bedges, 16);
    chk("b_sclk_period", bad_period, 0);
    chk("b_mosi_word", bbits, 16'h1234);
    chk("b_rx", rx_b, 16'h1234);
    @(negedge clk);
    chk("b_done_one_cycle", done_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation timed out");
  end

endmodule
